// File: rtl/mem_port_arb.sv
// mem_port_arb: shares the two data-memory ports between the MO-stage pipeline and a DMA/debug requester.
// The pipeline wins port conflicts; a starvation counter forces a one-cycle DMA grant that stalls the pipeline.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module mem_port_arb #(
  parameter int STARVE_MAX = 7,
  parameter int CNT_W      = 4
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_pl_req,
  input  logic                  iw_pl_mp,
  input  logic                  iw_pl_we,
  input  logic [`SIZE_ADDR-1:0] iw_pl_addr,
  input  logic [`SIZE_DATA-1:0] iw_pl_wdata,
  output logic [`SIZE_DATA-1:0] ow_pl_rdata,
  output logic                  ow_pl_stall,
  input  logic                  iw_dma_valid,
  input  logic                  iw_dma_mp,
  input  logic                  iw_dma_we,
  input  logic [`SIZE_ADDR-1:0] iw_dma_addr,
  input  logic [`SIZE_DATA-1:0] iw_dma_wdata,
  output logic                  ow_dma_ready,
  output logic                  ow_dma_rvalid,
  output logic [`SIZE_DATA-1:0] ow_dma_rdata,
  output logic [`SIZE_ADDR-1:0] ow_mem_addr  [0:1],
  output logic                  ow_mem_we    [0:1],
  output logic [`SIZE_DATA-1:0] ow_mem_wdata [0:1],
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata [0:1]
);

  typedef enum logic {NORMAL, FORCE} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STARVE_MAX - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_pl_stall;
  logic                  r_dma_rvalid;
  logic [`SIZE_DATA-1:0] r_dma_rdata;
  logic                  w_conflict;
  logic                  w_blocked;
  logic                  w_cnt_last;
  logic                  w_pl_go;
  logic                  w_dma_go;
  logic                  w_dma_rd;

  assign w_conflict = iw_pl_req & iw_dma_valid & (iw_pl_mp == iw_dma_mp);
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);
  assign w_dma_rd   = iw_dma_valid & w_dma_go & ~iw_dma_we;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) r_state <= NORMAL;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = NORMAL;
    case (r_state)
      NORMAL:  w_next_state = (w_blocked && w_cnt_last) ? FORCE : NORMAL;
      FORCE:   w_next_state = NORMAL;
      default: w_next_state = NORMAL;
    endcase
  end

  always_comb begin
    w_pl_go   = 1'b0;
    w_dma_go  = 1'b0;
    w_blocked = 1'b0;
    case (r_state)
      NORMAL: begin
        w_pl_go   = iw_pl_req;
        w_dma_go  = iw_dma_valid & ~w_conflict;
        w_blocked = iw_dma_valid & w_conflict;
      end
      FORCE: begin
        w_dma_go = iw_dma_valid;
      end
      default: begin
        w_pl_go = 1'b0;
      end
    endcase
  end

  // Counter holds consecutive blocked cycles; it wraps to zero on the cycle that triggers FORCE.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst)                                              r_cnt <= '0;
    else if ((r_state == FORCE) || !w_blocked || w_cnt_last) r_cnt <= '0;
    else                                                     r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_pl_stall   <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
    end else begin
      r_pl_stall   <= (w_next_state == FORCE);
      r_dma_rvalid <= w_dma_rd;
      if (w_dma_rd) r_dma_rdata <= iw_mem_rdata[iw_dma_mp];
    end
  end

  // Grants never overlap on one port, so the pipeline-first order only matters for readability.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      ow_mem_addr[p]  = '0;
      ow_mem_we[p]    = 1'b0;
      ow_mem_wdata[p] = '0;
      if (w_pl_go && (iw_pl_mp == 1'(p))) begin
        ow_mem_addr[p]  = iw_pl_addr;
        ow_mem_we[p]    = iw_pl_we;
        ow_mem_wdata[p] = iw_pl_wdata;
      end else if (w_dma_go && (iw_dma_mp == 1'(p))) begin
        ow_mem_addr[p]  = iw_dma_addr;
        ow_mem_we[p]    = iw_dma_we;
        ow_mem_wdata[p] = iw_dma_wdata;
      end
    end
  end

  assign ow_pl_rdata   = iw_mem_rdata[iw_pl_mp];
  assign ow_pl_stall   = r_pl_stall;
  assign ow_dma_ready  = w_dma_go;
  assign ow_dma_rvalid = r_dma_rvalid;
  assign ow_dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed test-plan steps followed by randomized traffic, all checked against a
// cycle-level model that counts consecutive blocked DMA cycles and grants ports by priority rules.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_mem_port_arb;

  localparam int STARVE_MAX = 7;
  localparam int AW = `SIZE_ADDR;
  localparam int DW = `SIZE_DATA;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          plReq, plMp, plWe;
  logic [AW-1:0] plAddr;
  logic [DW-1:0] plWdata;
  logic          dmaValid, dmaMp, dmaWe;
  logic [AW-1:0] dmaAddr;
  logic [DW-1:0] dmaWdata;
  logic [DW-1:0] memRdata [0:1];
  logic [DW-1:0] plRdata;
  logic          plStall, dmaReady, dmaRvalid;
  logic [DW-1:0] dmaRdata;
  logic [AW-1:0] memAddr  [0:1];
  logic          memWe    [0:1];
  logic [DW-1:0] memWdata [0:1];

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  bit            mForce;
  int            mRun;
  bit            mRvalid;
  logic [DW-1:0] mRdata;
  bit            mLastGo;
  bit            mLastStall;

  mem_port_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .iw_clk       (clk),
    .iw_rst       (rst),
    .iw_pl_req    (plReq),
    .iw_pl_mp     (plMp),
    .iw_pl_we     (plWe),
    .iw_pl_addr   (plAddr),
    .iw_pl_wdata  (plWdata),
    .ow_pl_rdata  (plRdata),
    .ow_pl_stall  (plStall),
    .iw_dma_valid (dmaValid),
    .iw_dma_mp    (dmaMp),
    .iw_dma_we    (dmaWe),
    .iw_dma_addr  (dmaAddr),
    .iw_dma_wdata (dmaWdata),
    .ow_dma_ready (dmaReady),
    .ow_dma_rvalid(dmaRvalid),
    .ow_dma_rdata (dmaRdata),
    .ow_mem_addr  (memAddr),
    .ow_mem_we    (memWe),
    .ow_mem_wdata (memWdata),
    .iw_mem_rdata (memRdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setPl(input logic req, input logic mp, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    plReq = req; plMp = mp; plWe = we; plAddr = addr; plWdata = wdata;
  endtask

  task automatic setDma(input logic valid, input logic mp, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    dmaValid = valid; dmaMp = mp; dmaWe = we; dmaAddr = addr; dmaWdata = wdata;
  endtask

  task automatic modelReset();
    mForce = 1'b0; mRun = 0; mRvalid = 1'b0; mRdata = '0; mLastGo = 1'b0; mLastStall = 1'b0;
  endtask

  // Checks every output against the model for the current inputs, then advances one clock.
  task automatic applyStimulus(input string tag);
    bit            conflict, plGo, dmaGo;
    logic [AW-1:0] eAddr  [0:1];
    logic          eWe    [0:1];
    logic [DW-1:0] eWdata [0:1];
    #1;
    conflict = plReq && dmaValid && (plMp == dmaMp);
    plGo     = !mForce && plReq;
    dmaGo    = dmaValid && (mForce || !conflict);
    for (int p = 0; p < 2; p++) begin
      eAddr[p] = '0; eWe[p] = 1'b0; eWdata[p] = '0;
      if (plGo && plMp == 1'(p)) begin
        eAddr[p] = plAddr; eWe[p] = plWe; eWdata[p] = plWdata;
      end else if (dmaGo && dmaMp == 1'(p)) begin
        eAddr[p] = dmaAddr; eWe[p] = dmaWe; eWdata[p] = dmaWdata;
      end
    end
    checkOutput({tag, ":ready"},   32'(dmaReady),  32'(dmaGo));
    checkOutput({tag, ":stall"},   32'(plStall),   32'(mForce));
    checkOutput({tag, ":rvalid"},  32'(dmaRvalid), 32'(mRvalid));
    checkOutput({tag, ":rdata"},   32'(dmaRdata),  32'(mRdata));
    checkOutput({tag, ":plRdata"}, 32'(plRdata),   32'(memRdata[plMp]));
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("%s:addr%0d", tag, p),  32'(memAddr[p]),  32'(eAddr[p]));
      checkOutput($sformatf("%s:we%0d", tag, p),    32'(memWe[p]),    32'(eWe[p]));
      checkOutput($sformatf("%s:wdata%0d", tag, p), 32'(memWdata[p]), 32'(eWdata[p]));
    end
    mLastGo    = dmaGo;
    mLastStall = mForce;
    @(posedge clk);
    if (dmaGo && !dmaWe) begin
      mRvalid = 1'b1;
      mRdata  = memRdata[dmaMp];
    end else begin
      mRvalid = 1'b0;
    end
    if (mForce) begin
      mForce = 1'b0;
      mRun   = 0;
    end else if (dmaValid && conflict) begin
      mRun++;
      if (mRun == STARVE_MAX) begin
        mForce = 1'b1;
        mRun   = 0;
      end
    end else begin
      mRun = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    setPl(1'b0, 1'b0, 1'b0, '0, '0);
    setDma(1'b0, 1'b0, 1'b0, '0, '0);
    memRdata[0] = '0;
    memRdata[1] = '0;
    modelReset();

    #1 rst = 1'b1;
    dmaValid = 1'b1;
    #1;
    checkOutput("reset:stall",  32'(plStall),   32'h0);
    checkOutput("reset:rvalid", 32'(dmaRvalid), 32'h0);
    checkOutput("reset:rdata",  32'(dmaRdata),  32'h0);
    checkOutput("reset:ready",  32'(dmaReady),  32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Split ports: pipeline store on mp0, DMA read on mp1
    setPl(1'b1, 1'b0, 1'b1, 16'h10, 32'hAA);
    setDma(1'b1, 1'b1, 1'b0, 16'h20, 32'h0);
    memRdata[0] = 32'h1111;
    memRdata[1] = 32'h55;
    #1;
    checkOutput("split:addr0",  32'(memAddr[0]),  32'h10);
    checkOutput("split:we0",    32'(memWe[0]),    32'h1);
    checkOutput("split:wdata0", 32'(memWdata[0]), 32'hAA);
    checkOutput("split:addr1",  32'(memAddr[1]),  32'h20);
    checkOutput("split:ready",  32'(dmaReady),    32'h1);
    applyStimulus("split");
    setPl(1'b0, 1'b0, 1'b0, '0, '0);
    setDma(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("split:rvalidNext", 32'(dmaRvalid), 32'h1);
    checkOutput("split:rdataNext",  32'(dmaRdata),  32'h55);
    checkOutput("split:stallNext",  32'(plStall),   32'h0);
    applyStimulus("splitIdle");

    // Continuous conflict on mp0 until the forced grant
    $display("[TB] starvation sequence");
    setPl(1'b1, 1'b0, 1'b0, 16'h30, 32'h0);
    setDma(1'b1, 1'b0, 1'b0, 16'h40, 32'h0);
    memRdata[0] = 32'h77;
    for (int c = 1; c <= STARVE_MAX; c++) begin
      #1;
      checkOutput($sformatf("conflict%0d:ready", c), 32'(dmaReady),   32'h0);
      checkOutput($sformatf("conflict%0d:addr0", c), 32'(memAddr[0]), 32'h30);
      checkOutput($sformatf("conflict%0d:stall", c), 32'(plStall),    32'h0);
      applyStimulus("conflict");
    end
    #1;
    checkOutput("force:stall", 32'(plStall),    32'h1);
    checkOutput("force:ready", 32'(dmaReady),   32'h1);
    checkOutput("force:addr0", 32'(memAddr[0]), 32'h40);
    checkOutput("force:we0",   32'(memWe[0]),   32'h0);
    applyStimulus("force");

    setDma(1'b1, 1'b0, 1'b1, 16'h50, 32'h1234);
    #1;
    checkOutput("after:stall",  32'(plStall),    32'h0);
    checkOutput("after:addr0",  32'(memAddr[0]), 32'h30);
    checkOutput("after:ready",  32'(dmaReady),   32'h0);
    checkOutput("after:rvalid", 32'(dmaRvalid),  32'h1);
    checkOutput("after:rdata",  32'(dmaRdata),   32'h77);
    applyStimulus("after");
    repeat (3) applyStimulus("count");

    // Valid drops at count 4, so a full run is needed again
    dmaValid = 1'b0;
    applyStimulus("idle");
    dmaValid = 1'b1;
    for (int c = 1; c <= STARVE_MAX; c++) begin
      #1;
      checkOutput($sformatf("recount%0d:ready", c), 32'(dmaReady), 32'h0);
      checkOutput($sformatf("recount%0d:stall", c), 32'(plStall),  32'h0);
      applyStimulus("recount");
    end
    #1;
    checkOutput("forceWr:stall",  32'(plStall),      32'h1);
    checkOutput("forceWr:ready",  32'(dmaReady),     32'h1);
    checkOutput("forceWr:we0",    32'(memWe[0]),     32'h1);
    checkOutput("forceWr:wdata0", 32'(memWdata[0]),  32'h1234);
    applyStimulus("forceWr");
    dmaValid = 1'b0;
    #1;
    checkOutput("forceWr:rvalid", 32'(dmaRvalid), 32'h0);
    checkOutput("forceWr:rdata",  32'(dmaRdata),  32'h77);
    applyStimulus("forceWrNext");

    // Valid withdrawn during FORCE: no transfer, one-cycle stall
    setPl(1'b1, 1'b1, 1'b0, 16'h31, 32'h0);
    setDma(1'b1, 1'b1, 1'b0, 16'h60, 32'h0);
    repeat (STARVE_MAX) applyStimulus("violate");
    dmaValid = 1'b0;
    #1;
    checkOutput("violate:stall", 32'(plStall),    32'h1);
    checkOutput("violate:ready", 32'(dmaReady),   32'h0);
    checkOutput("violate:addr1", 32'(memAddr[1]), 32'h0);
    applyStimulus("violateForce");
    #1;
    checkOutput("violate:stallNext", 32'(plStall), 32'h0);
    applyStimulus("violateNext");

    // Reset asserted in the middle of a FORCE cycle
    dmaValid = 1'b1;
    repeat (STARVE_MAX) applyStimulus("preRst");
    rst = 1'b1;
    #1;
    checkOutput("midRst:stall",  32'(plStall),   32'h0);
    checkOutput("midRst:rvalid", 32'(dmaRvalid), 32'h0);
    checkOutput("midRst:rdata",  32'(dmaRdata),  32'h0);
    modelReset();
    rst = 1'b0;
    applyStimulus("postRst");

    // Randomized traffic obeying the DMA hold and pipeline stall rules
    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      if (!(dmaValid && !mLastGo)) begin
        dmaValid = ($urandom_range(0, 3) != 0);
        dmaMp    = 1'($urandom_range(0, 1));
        dmaWe    = 1'($urandom_range(0, 1));
        dmaAddr  = AW'($urandom);
        dmaWdata = DW'($urandom);
      end
      if (!mLastStall) begin
        plReq   = ($urandom_range(0, 3) != 0);
        plMp    = ($urandom_range(0, 7) != 0) ? dmaMp : !dmaMp;
        plWe    = 1'($urandom_range(0, 1));
        plAddr  = AW'($urandom);
        plWdata = DW'($urandom);
      end
      memRdata[0] = DW'($urandom);
      memRdata[1] = DW'($urandom);
      applyStimulus("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Shares the two data-memory ports (mp 0/1) between the pipeline's memory-operation stage and a secondary DMA/debug requester. The pipeline has priority on a port conflict. A starvation counter forces a one-cycle DMA grant, during which the pipeline is stalled, once the DMA requester has been blocked for STARVE_MAX consecutive cycles. The block sits between the MO stage memory outputs and the memory macro.

## Interface
Parameters:
- STARVE_MAX, 7: number of consecutive blocked DMA cycles before a forced grant (range 1..15).
- CNT_W, 4: width of the starvation counter.

Ports:
- iw_clk  in  1  clock. One clock domain only.
- iw_rst  in  1  reset; asynchronous, active-high.
- iw_pl_req  in  1  pipeline memory access this cycle (load or store).
- iw_pl_mp  in  1  pipeline target port.
- iw_pl_we  in  1  pipeline store.
- iw_pl_addr  in  `SIZE_ADDR  pipeline address.
- iw_pl_wdata  in  `SIZE_DATA  pipeline store data.
- ow_pl_rdata  out  `SIZE_DATA  iw_mem_rdata[iw_pl_mp], passed through combinationally.
- ow_pl_stall  out  1  registered; pipeline must hold its access and the upstream stages.
- iw_dma_valid  in  1  DMA request valid.
- iw_dma_mp  in  1  DMA target port.
- iw_dma_we  in  1  DMA write.
- iw_dma_addr  in  `SIZE_ADDR  DMA address.
- iw_dma_wdata  in  `SIZE_DATA  DMA write data.
- ow_dma_ready  out  1  combinational; a transfer occurs when iw_dma_valid and ow_dma_ready are both high.
- ow_dma_rvalid  out  1  one-cycle pulse carrying DMA read data.
- ow_dma_rdata  out  `SIZE_DATA  registered DMA read data.
- ow_mem_addr[0:1]  out  `SIZE_ADDR  per-port address.
- ow_mem_we[0:1]  out  1  per-port write enable.
- ow_mem_wdata[0:1]  out  `SIZE_DATA  per-port write data.
- iw_mem_rdata[0:1]  in  `SIZE_DATA  per-port read data, valid in the same cycle as the address.

## Operation
FSM states: NORMAL, FORCE. Reset enters NORMAL.

Definitions:
- conflict = iw_pl_req & iw_dma_valid & (iw_pl_mp == iw_dma_mp).
- pl_go: the pipeline owns its port this cycle.
- dma_go: the DMA requester owns its port this cycle.

NORMAL:
- pl_go = iw_pl_req.
- dma_go = iw_dma_valid & ~conflict.
- blocked = iw_dma_valid & conflict.
- cnt: cleared on dma_go or when iw_dma_valid is low; otherwise incremented on blocked.
- If blocked and cnt == STARVE_MAX-1, next state is FORCE and cnt is cleared.

FORCE:
- ow_pl_stall = 1; pl_go = 0 regardless of port.
- dma_go = iw_dma_valid.
- The next state is always NORMAL.

Port outputs:
- The owning requester drives addr, we and wdata of its port.
- A port with no owner drives addr = 0, we = 0, wdata = 0.
- When the two requesters target different ports, both are served in the same cycle.

Handshake and DMA read data:
- ow_dma_ready = dma_go.
- A DMA requester must hold valid and its payload stable until it sees ready.
- On a DMA read transfer (valid & ready & ~we), ow_dma_rdata is loaded from iw_mem_rdata[iw_dma_mp], and ow_dma_rvalid = 1 for the next cycle only.
- A DMA write transfer leaves ow_dma_rdata unchanged and produces no rvalid.

Pipeline stall contract:
- While ow_pl_stall is high, the pipeline re-presents the same request the following cycle.

## Timing
- Reset values: ow_pl_stall = 0, ow_dma_rvalid = 0, ow_dma_rdata = 0, cnt = 0, state = NORMAL.
- Combinational outputs follow their inputs during reset in NORMAL rules.
- Grant latency, uncontested: 0 cycles (ready in the same cycle as valid).
- Worst-case DMA latency under continuous conflict: STARVE_MAX cycles blocked, then the grant in FORCE on cycle STARVE_MAX+1.
- Stall duration: exactly 1 cycle per forced grant.
- Maximum forced-grant rate: one per STARVE_MAX+1 cycles.
- DMA read data: ow_dma_rvalid rises 1 cycle after the transfer cycle.
- Back-to-back DMA reads give consecutive rvalid pulses.
- Valid dropped in FORCE (protocol violation): no transfer, return to NORMAL, stall still lasts 1 cycle.
- Reset mid-FORCE: stall drops asynchronously, counter clears, any pending rvalid is discarded.
- STARVE_MAX = 1: the first blocked cycle forces FORCE on the next cycle.
- The counter never exceeds STARVE_MAX-1, so there is no wrap.

## Test plan
- Reset: assert iw_rst mid-FORCE -> ow_pl_stall = 0, ow_dma_rvalid = 0, ow_dma_rdata = 0 immediately, without waiting for a clock edge; after release, state is NORMAL.
- Split ports: pipeline store to mp0 (addr 0x10, data 0xAA) with a DMA read of mp1 (addr 0x20, rdata 0x55) -> both ports driven in the same cycle; ow_dma_ready = 1; next cycle rvalid = 1 with rdata 0x55; stall stays 0.
- Conflict with priority: pipeline and DMA both on mp0 for 3 cycles, STARVE_MAX = 7 -> mp0 carries the pipeline's address each cycle; ready = 0; cnt reaches 3; stall 0.
- Starvation: continuous same-port conflict, STARVE_MAX = 7 -> ready = 0 for cycles 1-7; cycle 8 has stall = 1, ready = 1 and the DMA on the port with the pipeline's we low; cycle 9 returns to pipeline ownership with cnt = 0.
- DMA write under FORCE: DMA write 0x1234 -> ow_mem_we = 1 on the DMA port; no rvalid; ow_dma_rdata keeps its previous value.
- Idle DMA: iw_dma_valid drops mid-count at cnt = 4 -> cnt returns to 0; a subsequent conflict needs the full 7 cycles before FORCE.
